// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one iteration per cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  fncode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic [31:0] a_raw;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        fn_mul;
    logic        fn_div;
    logic        fn_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem;
    logic [33:0] diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Request decode and operand magnitudes for the signed forms
    always_comb begin
        fn_mul    = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
        fn_div    = (fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU);
        fn_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
        abs_a     = (fn_signed && op_a[31]) ? -op_a : op_a;
        abs_b     = (fn_signed && op_b[31]) ? -op_b : op_b;
    end

    // One iteration step for each algorithm plus final sign correction
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        rem      = {acc[63:32], acc[31]};
        diff     = {1'b0, rem} - {2'b00, opnd};
        div_next = diff[33] ? {rem[31:0], acc[30:0], 1'b0}
                            : {diff[31:0], acc[30:0], 1'b1};
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[31:0] : acc[31:0];
        r_fix    = neg_r ? -acc[63:32] : acc[63:32];
    end

    // Control FSM, iteration datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            a_raw    <= 32'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && (fn_mul || fn_div)) begin
                        opnd     <= fn_div ? abs_b : abs_a;
                        acc      <= {32'd0, fn_div ? abs_a : abs_b};
                        a_raw    <= op_a;
                        is_div   <= fn_div;
                        neg_q    <= fn_signed && (op_a[31] ^ op_b[31]);
                        neg_r    <= fn_signed && op_a[31];
                        div_zero <= (op_b == 32'd0);
                        cnt      <= 5'd0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else if (start && fncode == FUNCT_MTHI) begin
                        hi <= op_a;
                    end else if (start && fncode == FUNCT_MTLO) begin
                        lo <= op_a;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (div_zero) begin
                        hi <= a_raw;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Reference results come from plain 64-bit arithmetic.
module tb_mult_div_unit;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  fncode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    logic [31:0] mhi;
    logic [31:0] mlo;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .fncode (fncode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: returns {hi, lo}
    function automatic logic [63:0] ref_result(logic [5:0] fn,
                                               logic [31:0] a,
                                               logic [31:0] b);
        longint sa;
        longint sb_;
        longint q;
        longint r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        p   = 64'd0;
        case (fn)
            FN_MULT:  p = 64'(sa * sb_);
            FN_MULTU: p = 64'(a) * 64'(b);
            FN_DIV: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    p = {r[31:0], q[31:0]};
                end
            end
            FN_DIVU: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = {mhi, mlo};
        endcase
        return p;
    endfunction

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_done: got done=1, required no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_hi", 64'(hi), 64'(e.hi));
                check("done_lo", 64'(lo), 64'(e.lo));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Caller is just after a negedge; returns in the done cycle
    task automatic muldiv(logic [5:0] fn, logic [31:0] a, logic [31:0] b,
                          bit inject);
        logic [63:0] r;
        int nb;
        bit hold_ok;
        exp_t e;
        r = ref_result(fn, a, b);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.cyc = cyc + 34;
        sb.push_back(e);
        start = 1'b1;
        fncode = fn;
        op_a = a;
        op_b = b;
        @(negedge clk);
        nb = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            if (busy === 1'b1) nb++;
            if (hi !== mhi || lo !== mlo) hold_ok = 1'b0;
            if (inject && k == 10) begin
                start = 1'b1;
                fncode = FN_DIVU;
                op_a = 32'd9;
                op_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 64'(nb), 64'd33);
        check("busy_clear", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("hilo_hold", 64'(hold_ok), 64'd1);
        mhi = r[63:32];
        mlo = r[31:0];
    endtask

    task automatic mt(logic [5:0] fn, logic [31:0] a);
        start = 1'b1;
        fncode = fn;
        op_a = a;
        op_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        if (fn == FN_MTHI) mhi = a;
        else mlo = a;
        check("mt_hi", 64'(hi), 64'(mhi));
        check("mt_lo", 64'(lo), 64'(mlo));
        check("mt_busy_done", 64'({busy, done}), 64'd0);
    endtask

    task automatic other(logic [5:0] fn);
        start = 1'b1;
        fncode = fn;
        op_a = $urandom;
        op_b = $urandom;
        @(negedge clk);
        start = 1'b0;
        check("nop_hilo", {hi, lo}, {mhi, mlo});
        check("nop_busy", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 20)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd;
        logic [5:0] others [4];
        others[0] = FN_MFHI;
        others[1] = FN_MFLO;
        others[2] = 6'h20;
        others[3] = 6'h1C;
        mhi = 32'd0;
        mlo = 32'd0;
        reset = 1'b1;
        start = 1'b0;
        fncode = 6'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {30'd0, busy, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        muldiv(FN_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        muldiv(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        muldiv(FN_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        muldiv(FN_DIVU, 32'd100, 32'd7, 1'b0);
        muldiv(FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        muldiv(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        muldiv(FN_DIVU, 32'h1234_5678, 32'd0, 1'b0);
        muldiv(FN_DIV, 32'hF000_0001, 32'd0, 1'b0);
        @(negedge clk);
        mt(FN_MTHI, 32'hDEAD_BEEF);
        mt(FN_MTLO, 32'hCAFE_F00D);

        muldiv(FN_MULT, 32'd3, 32'd4, 1'b1);
        muldiv(FN_DIVU, 32'd9, 32'd3, 1'b0);

        start = 1'b1;
        fncode = FN_DIV;
        op_a = 32'd1000;
        op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy_done", 64'({busy, done}), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(nd), 64'd0);
        muldiv(FN_MULTU, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                muldiv(FN_MULT + 6'(sel % 4), rnd_operand(), rnd_operand(),
                       1'b0);
            end else if (sel == 6) begin
                mt(FN_MTHI, $urandom);
            end else if (sel == 7) begin
                mt(FN_MTLO, $urandom);
            end else if (sel == 8) begin
                other(others[$urandom_range(0, 3)]);
            end else begin
                @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
